// File: rtl/vt512_image_loader.sv
// Image-capture sequencer: decodes a one-word size/channel header from the dt24
// stream, then steers each pixel word to its channel memory at (row, col).
module vt512_image_loader #(
    parameter int DATA_WIDTH          = 24,
    parameter int MAX_IMAGE_SIZE      = 512,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9
) (
    input  logic                         dt24_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic                         dt24_we_i,
    input  logic [DATA_WIDTH-1:0]        dt24_data_i,
    output logic [2:0]                   mem_we_o,
    output logic [MAX_IMAGE_SIZE_LOG2:0] mem_row_o,
    output logic [MAX_IMAGE_SIZE_LOG2:0] mem_col_o,
    output logic [DATA_WIDTH-1:0]        mem_data_o,
    output logic [MAX_IMAGE_SIZE_LOG2:0] size_o,
    output logic                         three_ch_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int CW = MAX_IMAGE_SIZE_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_PIXEL  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [1:0]            ch_q, ch_d;
    logic [CW-1:0]         size_q, size_d;
    logic                  three_q, three_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2:0]            mem_we_q, mem_we_d;
    logic [CW-1:0]         mem_row_q, mem_row_d;
    logic [CW-1:0]         mem_col_q, mem_col_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    logic [CW-1:0] hdr_n_s;
    logic          hdr_three_s;
    logic          hdr_valid_s;
    logic [CW-1:0] last_idx_s;
    logic          ch_last_s;
    logic          col_last_s;
    logic          row_last_s;

    // The header carries N in the low index-width bits and channel mode just above.
    assign hdr_n_s     = dt24_data_i[CW-1:0];
    assign hdr_three_s = dt24_data_i[CW];
    assign hdr_valid_s = (hdr_n_s != {CW{1'b0}}) && (hdr_n_s <= CW'(MAX_IMAGE_SIZE));

    // Counters are CW bits wide, so N-1 for N = MAX_IMAGE_SIZE is representable.
    assign last_idx_s = size_q - CW'(1);
    assign ch_last_s  = !three_q || (ch_q == 2'd2);
    assign col_last_s = (col_q == last_idx_s);
    assign row_last_s = (row_q == last_idx_s);

    // Next-state, counter advance and write-port decode.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        ch_d       = ch_q;
        size_d     = size_q;
        three_d    = three_q;
        err_d      = err_q;
        done_d     = 1'b0;
        mem_we_d   = 3'b000;
        mem_row_d  = mem_row_q;
        mem_col_d  = mem_col_q;
        mem_data_d = mem_data_q;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_HEADER;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HEADER: begin
                    if (dt24_we_i && hdr_valid_s) begin
                        size_d  = hdr_n_s;
                        three_d = hdr_three_s;
                        row_d   = {CW{1'b0}};
                        col_d   = {CW{1'b0}};
                        ch_d    = 2'd0;
                        state_d = ST_PIXEL;
                    end else if (dt24_we_i) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HEADER;
                    end
                end
                ST_PIXEL: begin
                    if (dt24_we_i) begin
                        mem_we_d   = 3'b001 << ch_q;
                        mem_row_d  = row_q;
                        mem_col_d  = col_q;
                        mem_data_d = dt24_data_i;
                        if (ch_last_s && col_last_s && row_last_s) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else if (ch_last_s && col_last_s) begin
                            ch_d  = 2'd0;
                            col_d = {CW{1'b0}};
                            row_d = row_q + CW'(1);
                        end else if (ch_last_s) begin
                            ch_d  = 2'd0;
                            col_d = col_q + CW'(1);
                        end else begin
                            ch_d = ch_q + 2'd1;
                        end
                    end else begin
                        state_d = ST_PIXEL;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge dt24_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            row_q      <= {CW{1'b0}};
            col_q      <= {CW{1'b0}};
            ch_q       <= 2'd0;
            size_q     <= {CW{1'b0}};
            three_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_we_q   <= 3'b000;
            mem_row_q  <= {CW{1'b0}};
            mem_col_q  <= {CW{1'b0}};
            mem_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ch_q       <= ch_d;
            size_q     <= size_d;
            three_q    <= three_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_we_q   <= mem_we_d;
            mem_row_q  <= mem_row_d;
            mem_col_q  <= mem_col_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign mem_we_o   = mem_we_q;
    assign mem_row_o  = mem_row_q;
    assign mem_col_o  = mem_col_q;
    assign mem_data_o = mem_data_q;
    assign size_o     = size_q;
    assign three_ch_o = three_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
